// File: rtl/beep_sched.sv
// Buzzer scheduler: latches tick/fail/win requests, grants by fixed priority and
// plays N tone beeps per source. Optional BEEP_PREEMPT_EN lets higher sources cut in.
module beep_sched #(
  parameter int TONE_DIV = 500,
  parameter int ON_CYC   = 2500000,
  parameter int OFF_CYC  = 2500000,
  parameter int NB_TICK  = 1,
  parameter int NB_FAIL  = 3,
  parameter int NB_WIN   = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [2:0] req_i,
  output logic       beep_o,
  output logic       busy_o,
  output logic [2:0] grant_o,
  output logic       done_o
);
  localparam int PW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(TONE_DIV - 1);
  localparam logic [23:0]   ON_LAST  = 24'(ON_CYC - 1);
  localparam logic [23:0]   OFF_LAST = 24'(OFF_CYC - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_e;

  state_e        state_q, state_d;
  logic [2:0]    pend_q, pend_d, grant_q, grant_d, rem_q, rem_d, top;
  logic [PW-1:0] ph_q, ph_d;
  logic [23:0]   cnt_q, cnt_d;
  logic          beep_q, beep_d, done_q, done_d, start;

  function automatic logic [2:0] nb_of(input logic [2:0] g);
    case (g)
      3'b100:  nb_of = 3'(NB_WIN);
      3'b010:  nb_of = 3'(NB_FAIL);
      3'b001:  nb_of = 3'(NB_TICK);
      default: nb_of = 3'd0;
    endcase
  endfunction

  always_comb begin
    top = pend_q[2] ? 3'b100 : pend_q[1] ? 3'b010 : pend_q[0] ? 3'b001 : 3'b000;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rem_d   = rem_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    beep_d  = beep_q;
    done_d  = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: start = (pend_q != 3'b000);
      ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = OFF;
          beep_d  = 1'b0;
          rem_d   = rem_q - 3'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
          if (ph_q == PH_LAST) begin
            ph_d   = '0;
            beep_d = ~beep_q;
          end else begin
            ph_d = ph_q + PW'(1);
          end
        end
      end
      OFF: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d = '0;
          if (rem_q != 3'd0) begin
            state_d = ON;
            ph_d    = '0;
            beep_d  = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = 3'b000;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BEEP_PREEMPT_EN
    // One-hot codes: a numerically larger code is always a higher priority source.
    if (state_q != IDLE && top > grant_q) start = 1'b1;
`endif
    if (start) begin
      state_d = ON;
      grant_d = top;
      rem_d   = nb_of(top);
      ph_d    = '0;
      cnt_d   = '0;
      beep_d  = 1'b1;
      done_d  = 1'b0;
    end
    // A request landing on its own grant edge survives, so the pattern replays.
    pend_d = (pend_q & ~(start ? top : 3'b000)) | req_i;
    if (!en_i) begin
      state_d = IDLE;
      grant_d = 3'b000;
      pend_d  = 3'b000;
      rem_d   = 3'd0;
      ph_d    = '0;
      cnt_d   = '0;
      beep_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= 3'b000;
      grant_q <= 3'b000;
      rem_q   <= 3'd0;
      ph_q    <= '0;
      cnt_q   <= '0;
      beep_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      rem_q   <= rem_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      beep_q  <= beep_d;
      done_q  <= done_d;
    end
  end

  assign beep_o  = beep_q;
  assign busy_o  = (state_q != IDLE);
  assign grant_o = grant_q;
  assign done_o  = done_q;
endmodule

// File: tb/tb_beep_sched.sv
// Bench for beep_sched: constant vector table, directed corner sequences and random
// traffic against a pattern-time reference model (honours BEEP_PREEMPT_EN).
module tb_beep_sched;
  localparam int TD = 2, ONC = 8, OFFC = 4, PER = ONC + OFFC;

  logic clk = 1'b0, rst, en;
  logic [2:0] req, grant;
  logic beep, busy, done;

  always #5 clk = ~clk;

  beep_sched #(.TONE_DIV(TD), .ON_CYC(ONC), .OFF_CYC(OFFC),
               .NB_TICK(1), .NB_FAIL(2), .NB_WIN(3)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req),
    .beep_o(beep), .busy_o(busy), .grant_o(grant), .done_o(done));

  int n_pass = 0, n_total = 0;
  int m_src = -1, m_t = 0;
  bit [2:0] m_pend = 3'b000;
  bit m_done = 1'b0;
  logic [2:0] gseq[$];
  logic [2:0] gprev = 3'b000;
  int dcount = 0;
  bit busy_seen = 1'b0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] req;
    logic [5:0] exp;  // {beep, busy, grant, done}
  } vec_t;
  vec_t tv[16];

  function automatic int nb_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 2 : 3;
  endfunction

  function automatic logic [5:0] model_out();
    int k;
    logic b;
    k = m_t % PER;
    b = (m_src >= 0) && (k < ONC) && (((k / TD) % 2) == 0);
    return {b, m_src >= 0, (m_src >= 0) ? 3'(1 << m_src) : 3'b000, m_done};
  endfunction

  task automatic model_update(input logic r, input logic e, input logic [2:0] q);
    int hp, st, os;
    if (r || !e) begin
      m_src = -1; m_t = 0; m_pend = 3'b000; m_done = 1'b0;
    end else begin
      hp = m_pend[2] ? 2 : m_pend[1] ? 1 : m_pend[0] ? 0 : -1;
      st = -1;
      os = m_src;
      m_done = 1'b0;
      if (m_src < 0) st = hp;
      else begin
        m_t++;
        if (m_t == nb_of(m_src) * PER) begin m_src = -1; m_done = 1'b1; end
`ifdef BEEP_PREEMPT_EN
        if (hp > os) st = hp;
`endif
      end
      if (st >= 0) begin m_src = st; m_t = 0; m_done = 1'b0; m_pend[st] = 1'b0; end
      m_pend = m_pend | q;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] q);
    rst = r; en = e; req = q;
    @(posedge clk);
    model_update(r, e, q);
    #1;
    chk("model", {26'd0, beep, busy, grant, done}, {26'd0, model_out()});
    if (grant != gprev && grant != 3'b000) gseq.push_back(grant);
    gprev = grant;
    if (done) dcount++;
    if (busy || beep || done || grant != 3'b000) busy_seen = 1'b1;
  endtask

  task automatic clr_obs();
    gseq.delete(); dcount = 0; busy_seen = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 3'b000);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = 3'b000;
    tv[0]  = '{1'b1, 1'b1, 3'b000, 6'b000000};
    tv[1]  = '{1'b0, 1'b1, 3'b001, 6'b000000};
    tv[2]  = '{1'b0, 1'b1, 3'b000, 6'b110010};
    tv[3]  = '{1'b0, 1'b1, 3'b000, 6'b110010};
    tv[4]  = '{1'b0, 1'b1, 3'b000, 6'b010010};
    tv[5]  = '{1'b0, 1'b1, 3'b000, 6'b010010};
    tv[6]  = '{1'b0, 1'b1, 3'b000, 6'b110010};
    tv[7]  = '{1'b0, 1'b1, 3'b000, 6'b110010};
    tv[8]  = '{1'b0, 1'b1, 3'b000, 6'b010010};
    tv[9]  = '{1'b0, 1'b1, 3'b000, 6'b010010};
    tv[10] = '{1'b0, 1'b1, 3'b000, 6'b010010};
    tv[11] = '{1'b0, 1'b1, 3'b000, 6'b010010};
    tv[12] = '{1'b0, 1'b1, 3'b000, 6'b010010};
    tv[13] = '{1'b0, 1'b1, 3'b000, 6'b010010};
    tv[14] = '{1'b0, 1'b1, 3'b000, 6'b000001};
    tv[15] = '{1'b0, 1'b1, 3'b000, 6'b000000};

    // Idle after reset for 50 cycles.
    step(1'b1, 1'b1, 3'b000);
    chk("reset_outs", {28'd0, beep, busy, grant, done} , 32'd0);
    clr_obs();
    run(50);
    chk("idle_quiet", {31'd0, busy_seen}, 32'd0);

    // Single tick pattern from constant table.
    for (int i = 0; i < 16; i++) begin
      step(tv[i].rst, tv[i].en, tv[i].req);
      chk($sformatf("vec%0d", i), {26'd0, beep, busy, grant, done}, {26'd0, tv[i].exp});
    end

    // All three at once: win, fail, tick in order with one idle cycle between.
    clr_obs();
    step(1'b0, 1'b1, 3'b111);
    run(36 + 1 + 24 + 1 + 12 + 4);
    chk("prio_ngrants", gseq.size(), 3);
    if (gseq.size() == 3) chk("prio_order", {23'd0, gseq[0], gseq[1], gseq[2]}, {23'd0, 9'b100_010_001});
    chk("prio_dones", dcount, 3);

    // Win request arrives 3 cycles into tick ON.
    clr_obs();
    step(1'b0, 1'b1, 3'b001);
    run(3);
    step(1'b0, 1'b1, 3'b100);
    run(60);
    chk("late_win_ngrants", gseq.size(), 2);
    if (gseq.size() == 2) chk("late_win_order", {26'd0, gseq[0], gseq[1]}, {26'd0, 6'b001_100});
`ifdef BEEP_PREEMPT_EN
    chk("late_win_dones", dcount, 1);
`else
    chk("late_win_dones", dcount, 2);
`endif

    // en dropped for one cycle during win OFF, with a fail request held.
    clr_obs();
    step(1'b0, 1'b1, 3'b100);
    run(10);
    chk("en_pre_off", {29'd0, beep, busy, 1'b1}, {29'd0, 3'b011});
    step(1'b0, 1'b0, 3'b010);
    chk("en_abort", {26'd0, beep, busy, grant, done}, 32'd0);
    chk("en_abort_dones", dcount, 0);
    busy_seen = 1'b0;
    run(40);
    chk("en_no_fail", {31'd0, busy_seen}, 32'd0);

    // Reset mid-ON of fail, then a tick plays normally.
    clr_obs();
    step(1'b0, 1'b1, 3'b010);
    run(4);
    chk("fail_playing", {29'd0, grant}, {29'd0, 3'b010});
    step(1'b1, 1'b1, 3'b000);
    chk("rst_mid", {26'd0, beep, busy, grant, done}, 32'd0);
    clr_obs();
    step(1'b0, 1'b1, 3'b001);
    run(14);
    chk("post_rst_dones", dcount, 1);
    chk("post_rst_grant", gseq.size(), 1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic r, e;
      logic [2:0] q;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 39) != 0);
      for (int b = 0; b < 3; b++) q[b] = ($urandom_range(0, 24) == 0);
      step(r, e, q);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
